// File: rtl/i2c_target_fifo.sv
// I2C target engine: oversampled SCL/SDA, 7-bit address match, RX FIFO for writes
// and a valid/ready TX port for reads. SDA is only ever pulled low through sda_oe.
module i2c_target_fifo #(
  parameter logic [6:0] OWN_ADDR    = 7'h50,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       RESET_IN,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [6:0] ADRESS_OUT,
  output logic       rw_out,
  output logic       addr_hit,
  output logic [7:0] DATA_OUT,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overflow,
  output logic       tx_underrun,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  state_t      state;
  state_t      state_next;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_next;
  logic [6:0]  shift;
  logic [6:0]  shift_next;
  logic        ack_phase;
  logic        ack_phase_next;
  logic        ack_ok;
  logic        ack_ok_next;
  logic        sda_oe_next;
  logic        busy_next;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic        addr_load;
  logic        push;
  logic        pop;
  logic        hit;
  logic        overflow;
  logic        tx_take;
  logic        underrun;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;

  // Idle bus is high, so the synchronisers reset to 1 to avoid a phantom edge
  always_ff @(posedge clk or negedge RESET_IN) begin
    if (!RESET_IN) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_byte   = {shift, sda_s};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid   = ~fifo_empty;
  assign pop        = rx_valid & rx_ready;
  assign DATA_OUT   = mem[rd_ptr[AW-1:0]];
  assign tx_ready   = tx_take;

  always_ff @(posedge clk or negedge RESET_IN) begin
    if (!RESET_IN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= rx_byte;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 7'd0;
      ack_phase   <= 1'b0;
      ack_ok      <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      ADRESS_OUT  <= 7'd0;
      rw_out      <= 1'b0;
      addr_hit    <= 1'b0;
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shift       <= shift_next;
      ack_phase   <= ack_phase_next;
      ack_ok      <= ack_ok_next;
      sda_oe      <= sda_oe_next;
      busy        <= busy_next;
      addr_hit    <= hit;
      rx_overflow <= overflow;
      tx_underrun <= underrun;
      if (addr_load) begin
        ADRESS_OUT <= rx_byte[7:1];
        rw_out     <= rx_byte[0];
      end
    end
  end

  // ack_phase separates the SCL fall that starts an ACK slot from the one that ends it
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    ack_phase_next = ack_phase;
    ack_ok_next    = ack_ok;
    sda_oe_next    = sda_oe;
    busy_next      = busy;
    tx_byte        = IDLE_BYTE;
    addr_load      = 1'b0;
    push           = 1'b0;
    hit            = 1'b0;
    overflow       = 1'b0;
    tx_take        = 1'b0;
    underrun       = 1'b0;

    case (state)
      IDLE: begin
        sda_oe_next = 1'b0;
      end

      ADDR: begin
        if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            addr_load      = 1'b1;
            bit_cnt_next   = 3'd0;
            ack_phase_next = 1'b0;
            state_next     = (rx_byte[7:1] == OWN_ADDR) ? ADDR_ACK : IGNORE;
          end
        end
      end

      ADDR_ACK: begin
        if (scl_fall) begin
          if (!ack_phase) begin
            sda_oe_next    = 1'b1;
            ack_phase_next = 1'b1;
            hit            = 1'b1;
          end else begin
            ack_phase_next = 1'b0;
            bit_cnt_next   = 3'd0;
            if (rw_out) begin
              state_next = RD_LOAD;
            end else begin
              sda_oe_next = 1'b0;
              state_next  = WR_DATA;
            end
          end
        end
      end

      WR_DATA: begin
        if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bit_cnt_next   = 3'd0;
            ack_phase_next = 1'b0;
            state_next     = WR_ACK;
            if (!fifo_full || pop) begin
              push        = 1'b1;
              ack_ok_next = 1'b1;
            end else begin
              overflow    = 1'b1;
              ack_ok_next = 1'b0;
            end
          end
        end
      end

      WR_ACK: begin
        if (scl_fall) begin
          if (!ack_phase) begin
            sda_oe_next    = ack_ok;
            ack_phase_next = 1'b1;
          end else begin
            sda_oe_next    = 1'b0;
            ack_phase_next = 1'b0;
            state_next     = WR_DATA;
          end
        end
      end

      // The MSB goes straight onto sda_oe; the remaining seven bits wait in shift
      RD_LOAD: begin
        if (tx_valid) begin
          tx_byte = tx_data;
          tx_take = 1'b1;
        end else begin
          tx_byte  = IDLE_BYTE;
          underrun = 1'b1;
        end
        shift_next   = tx_byte[6:0];
        sda_oe_next  = ~tx_byte[7];
        bit_cnt_next = 3'd0;
        state_next   = RD_DATA;
      end

      RD_DATA: begin
        if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 3'd0;
            state_next   = RD_ACK;
          end else begin
            sda_oe_next  = ~shift[6];
            shift_next   = {shift[5:0], 1'b0};
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end

      RD_ACK: begin
        if (scl_rise) begin
          ack_ok_next = ~sda_s;
        end
        if (scl_fall) begin
          state_next = ack_ok ? RD_LOAD : IGNORE;
        end
      end

      IGNORE: begin
        sda_oe_next = 1'b0;
      end

      default: begin
        state_next  = IDLE;
        sda_oe_next = 1'b0;
      end
    endcase

    // Bus conditions win over whatever the byte engine was doing
    if (start_det || stop_det) begin
      addr_load      = 1'b0;
      push           = 1'b0;
      hit            = 1'b0;
      overflow       = 1'b0;
      tx_take        = 1'b0;
      underrun       = 1'b0;
      sda_oe_next    = 1'b0;
      bit_cnt_next   = 3'd0;
      ack_phase_next = 1'b0;
    end
    if (start_det) begin
      state_next = ADDR;
      busy_next  = 1'b1;
    end else if (stop_det) begin
      state_next = IDLE;
      busy_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_target_fifo.sv
// Bench for i2c_target_fifo: a bit-banged I2C master against a queue-based
// model of the RX FIFO, TX supply and event pulse counts.
module tb_i2c_target_fifo;

  localparam logic [6:0] OWN   = 7'h50;
  localparam int         DEPTH = 8;
  localparam logic [7:0] IDLE  = 8'hFF;

  logic       clk = 1'b0;
  logic       RESET_IN = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda_bus;
  logic       sda_oe;
  logic [6:0] ADRESS_OUT;
  logic       rw_out;
  logic       addr_hit;
  logic [7:0] DATA_OUT;
  logic       rx_valid;
  logic       tx_ready;
  logic       rx_overflow;
  logic       tx_underrun;
  logic       busy;

  int checkCount = 0;
  int errorCount = 0;

  int hitCount = 0;
  int ovfCount = 0;
  int underCount = 0;
  int readyCount = 0;

  int expHit = 0;
  int expOvf = 0;
  int expUnder = 0;
  int expReady = 0;

  logic [7:0] fifoModel[$];
  logic [7:0] stimBytes[$];
  logic [7:0] txSupply[$];
  int         modelTxIdx = 0;
  int         txIndex = 0;
  logic       popPending = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_fifo dut (
    .clk         (clk),
    .RESET_IN    (RESET_IN),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .ADRESS_OUT  (ADRESS_OUT),
    .rw_out      (rw_out),
    .addr_hit    (addr_hit),
    .DATA_OUT    (DATA_OUT),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_overflow (rx_overflow),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (addr_hit === 1'b1) hitCount++;
    if (rx_overflow === 1'b1) ovfCount++;
    if (tx_underrun === 1'b1) underCount++;
  end

  // TX source: a byte is retired one negedge after tx_ready, i.e. after the taking edge
  always @(negedge clk) begin
    if (popPending) begin
      txIndex++;
      popPending = 1'b0;
    end
    if (tx_ready === 1'b1) begin
      readyCount++;
      popPending = 1'b1;
    end
    if (txIndex < txSupply.size()) begin
      tx_valid = 1'b1;
      tx_data  = txSupply[txIndex];
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic quarter();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic clockBit(input logic b, output logic seen);
    sda_m = b;
    quarter();
    scl_m = 1'b1;
    quarter();
    seen = sda_bus;
    quarter();
    scl_m = 1'b0;
    quarter();
  endtask

  task automatic busStart();
    sda_m = 1'b1;
    quarter();
    scl_m = 1'b1;
    quarter();
    sda_m = 1'b0;
    quarter();
    scl_m = 1'b0;
    quarter();
  endtask

  task automatic busStop();
    sda_m = 1'b0;
    quarter();
    scl_m = 1'b1;
    quarter();
    sda_m = 1'b1;
    quarter();
    quarter();
  endtask

  task automatic sendByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], s);
    clockBit(1'b1, s);
    acked = ~s;
  endtask

  task automatic recvByte(input logic masterAck, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      b[i] = s;
    end
    clockBit(~masterAck, s);
  endtask

  task automatic startTxn();
    busStart();
    @(negedge clk);
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic endTxn(input logic [6:0] a, input logic rw);
    busStop();
    @(negedge clk);
    checkOutput("busy_after_stop", busy, 0);
    checkOutput("addr_out", ADRESS_OUT, a);
    checkOutput("rw_out", rw_out, rw);
    checkOutput("addr_hit_count", hitCount, expHit);
    checkOutput("overflow_count", ovfCount, expOvf);
    checkOutput("tx_ready_count", readyCount, expReady);
    checkOutput("underrun_count", underCount, expUnder);
  endtask

  task automatic addrPhase(input logic [6:0] a, input logic rw);
    logic acked;
    sendByte({a, rw}, acked);
    checkOutput("addr_ack", acked, (a == OWN));
    if (a == OWN) expHit++;
  endtask

  task automatic writeBytes(input logic match);
    logic acked;
    foreach (stimBytes[i]) begin
      sendByte(stimBytes[i], acked);
      if (!match) begin
        checkOutput("wr_ignored_nack", acked, 0);
      end else if (fifoModel.size() < DEPTH) begin
        checkOutput("wr_ack", acked, 1);
        fifoModel.push_back(stimBytes[i]);
      end else begin
        checkOutput("wr_overflow_nack", acked, 0);
        expOvf++;
      end
    end
  endtask

  task automatic readBytes(input int n);
    logic [7:0] b;
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      if (modelTxIdx < txSupply.size()) begin
        exp = txSupply[modelTxIdx];
        modelTxIdx++;
        expReady++;
      end else begin
        exp = IDLE;
        expUnder++;
      end
      recvByte(i < n - 1, b);
      checkOutput("rd_byte", b, exp);
    end
  endtask

  task automatic drainFifo();
    logic [7:0] exp;
    while (fifoModel.size() > 0) begin
      exp = fifoModel.pop_front();
      @(negedge clk);
      checkOutput("rx_valid", rx_valid, 1);
      checkOutput("rx_head", DATA_OUT, exp);
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
    end
    @(negedge clk);
    checkOutput("rx_empty_after_drain", rx_valid, 0);
  endtask

  // kind 0: write to own address, 1: write to another address, 2: read own address
  task automatic applyStimulus(input int kind);
    logic [6:0] a;
    int         n;
    int         k;
    stimBytes.delete();
    case (kind)
      0: begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) stimBytes.push_back(8'($urandom));
        startTxn();
        addrPhase(OWN, 1'b0);
        writeBytes(1'b1);
        endTxn(OWN, 1'b0);
      end
      1: begin
        a = 7'($urandom_range(0, 127));
        if (a == OWN) a = a ^ 7'h01;
        n = $urandom_range(1, 2);
        for (int i = 0; i < n; i++) stimBytes.push_back(8'($urandom));
        startTxn();
        addrPhase(a, 1'b0);
        writeBytes(1'b0);
        endTxn(a, 1'b0);
      end
      default: begin
        n = $urandom_range(1, 3);
        k = $urandom_range(0, n);
        for (int i = 0; i < k; i++) txSupply.push_back(8'($urandom));
        startTxn();
        addrPhase(OWN, 1'b1);
        readBytes(n);
        endTxn(OWN, 1'b1);
      end
    endcase
  endtask

  initial begin
    logic s;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_sda_oe", sda_oe, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_addr_hit", addr_hit, 0);
    checkOutput("reset_addr_out", ADRESS_OUT, 0);
    checkOutput("reset_rw_out", rw_out, 0);
    checkOutput("reset_overflow", rx_overflow, 0);
    checkOutput("reset_underrun", tx_underrun, 0);
    RESET_IN = 1'b1;
    repeat (10) @(posedge clk);

    $display("[TB] directed write A5,3C");
    stimBytes.delete();
    stimBytes.push_back(8'hA5);
    stimBytes.push_back(8'h3C);
    startTxn();
    addrPhase(OWN, 1'b0);
    writeBytes(1'b1);
    endTxn(OWN, 1'b0);
    drainFifo();

    $display("[TB] address mismatch");
    stimBytes.delete();
    stimBytes.push_back(8'h11);
    startTxn();
    addrPhase(7'h51, 1'b0);
    writeBytes(1'b0);
    endTxn(7'h51, 1'b0);
    drainFifo();

    $display("[TB] overflow with nine bytes");
    stimBytes.delete();
    for (int i = 0; i < DEPTH + 1; i++) stimBytes.push_back(8'($urandom));
    startTxn();
    addrPhase(OWN, 1'b0);
    writeBytes(1'b1);
    endTxn(OWN, 1'b0);
    drainFifo();

    $display("[TB] read C3 then underrun");
    txSupply.push_back(8'hC3);
    startTxn();
    addrPhase(OWN, 1'b1);
    readBytes(2);
    endTxn(OWN, 1'b1);

    $display("[TB] repeated start write then read");
    stimBytes.delete();
    stimBytes.push_back(8'h77);
    startTxn();
    addrPhase(OWN, 1'b0);
    writeBytes(1'b1);
    busStart();
    addrPhase(OWN, 1'b1);
    readBytes(1);
    endTxn(OWN, 1'b1);
    drainFifo();

    $display("[TB] randomized transactions");
    for (int t = 0; t < 14; t++) begin
      applyStimulus($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) drainFifo();
    end
    drainFifo();

    $display("[TB] reset during read bit 4");
    stimBytes.delete();
    stimBytes.push_back(8'h5A);
    startTxn();
    addrPhase(OWN, 1'b0);
    writeBytes(1'b1);
    endTxn(OWN, 1'b0);
    txSupply.push_back(8'h00);
    startTxn();
    addrPhase(OWN, 1'b1);
    modelTxIdx++;
    expReady++;
    for (int i = 0; i < 3; i++) begin
      clockBit(1'b1, s);
      checkOutput("rd_zero_bit", s, 0);
    end
    sda_m = 1'b1;
    quarter();
    scl_m = 1'b1;
    quarter();
    @(negedge clk);
    checkOutput("sda_oe_before_reset", sda_oe, 1);
    RESET_IN = 1'b0;
    #1;
    checkOutput("sda_oe_in_reset", sda_oe, 0);
    checkOutput("busy_in_reset", busy, 0);
    checkOutput("rx_valid_in_reset", rx_valid, 0);
    fifoModel.delete();
    repeat (4) @(posedge clk);
    sda_m = 1'b1;
    scl_m = 1'b1;
    @(negedge clk);
    RESET_IN = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("tx_ready_count_reset", readyCount, expReady);

    stimBytes.delete();
    stimBytes.push_back(8'h96);
    startTxn();
    addrPhase(OWN, 1'b0);
    writeBytes(1'b1);
    endTxn(OWN, 1'b0);
    drainFifo();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

  initial begin
    #800us;
    errorCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule
